pmod_switch_debounce: RTL and testbench

Eight-channel input conditioner for the PMOD switch module. It synchronises the raw switch pins into the `clk` domain and rejects contact bounce on each channel independently. It presents clean debounced levels plus one-cycle rise/fall event pulses. It sits directly upstream of the switch-to-LED stage, which consumes `sw_state` in place of the raw pins and keeps its inversion.

---
 rtl/pmod_switch_debounce_pkg.sv | 16 +
 rtl/pmod_switch_debounce_channel.sv | 67 ++++++
 rtl/pmod_switch_debounce.sv | 51 +++++
 tb/tb_pmod_switch_debounce.sv | 163 ++++++++++++++++
 4 files changed

// File: rtl/pmod_switch_debounce_pkg.sv
// Shared constants and helpers for the PMOD switch input blocks.
// Imported by the debounce top and its per-channel worker.
package pmod_switch_debounce_pkg;

  localparam logic PMOD_IDLE_LEVEL = 1'b1;

  localparam int unsigned PMOD_DEBOUNCE_10MS_12MHZ = 120000;

  // Counter width is max(1, clog2(n)) so n == 1 still yields a 1-bit counter.
  function automatic int unsigned cnt_width(input int unsigned n);
    if (n <= 2)
      return 1;
    return $clog2(n);
  endfunction

endpackage

// File: rtl/pmod_switch_debounce_channel.sv
// One debounce channel: 2-flop synchroniser, stability counter,
// debounced level and registered rise/fall event pulses.
module debounce_channel
  import pmod_switch_debounce_pkg::*;
#(
  parameter int unsigned STABLE_CYCLES = PMOD_DEBOUNCE_10MS_12MHZ,
  parameter logic        IDLE_LEVEL    = PMOD_IDLE_LEVEL
) (
  input  logic clk,
  input  logic rst,
  input  logic sw_in,
  output logic state,
  output logic rise,
  output logic fall,
  output logic ev_d
);

  localparam int unsigned CW = cnt_width(STABLE_CYCLES);
  localparam logic [CW-1:0] TERM = CW'(STABLE_CYCLES - 1);

  logic          sync1_q;
  logic          sync_q;
  logic          state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          rise_q, rise_d;
  logic          fall_q, fall_d;

  always_comb begin
    state_d = state_q;
    cnt_d   = '0;
    rise_d  = 1'b0;
    fall_d  = 1'b0;
    if (sync_q != state_q) begin
      if (cnt_q == TERM) begin
        state_d = sync_q;
        rise_d  = sync_q;
        fall_d  = ~sync_q;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q <= IDLE_LEVEL;
      sync_q  <= IDLE_LEVEL;
      state_q <= IDLE_LEVEL;
      cnt_q   <= '0;
      rise_q  <= 1'b0;
      fall_q  <= 1'b0;
    end else begin
      sync1_q <= sw_in;
      sync_q  <= sync1_q;
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rise_q  <= rise_d;
      fall_q  <= fall_d;
    end
  end

  assign state = state_q;
  assign rise  = rise_q;
  assign fall  = fall_q;
  assign ev_d  = rise_d | fall_d;

endmodule

// File: rtl/pmod_switch_debounce.sv
// Eight-channel PMOD switch conditioner: per-channel debounce plus
// a registered any-change flag aligned with the event pulses.
module pmod_switch_debounce
  import pmod_switch_debounce_pkg::*;
#(
  parameter int unsigned CHANNELS      = 8,
  parameter int unsigned STABLE_CYCLES = PMOD_DEBOUNCE_10MS_12MHZ,
  parameter logic        IDLE_LEVEL    = PMOD_IDLE_LEVEL
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [CHANNELS-1:0] sw_in,
  output logic [CHANNELS-1:0] sw_state,
  output logic [CHANNELS-1:0] sw_rise,
  output logic [CHANNELS-1:0] sw_fall,
  output logic                sw_changed
);

  logic [CHANNELS-1:0] ev_d;
  logic                changed_q, changed_d;

  for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
    debounce_channel #(
      .STABLE_CYCLES(STABLE_CYCLES),
      .IDLE_LEVEL   (IDLE_LEVEL)
    ) u_ch (
      .clk  (clk),
      .rst  (rst),
      .sw_in(sw_in[i]),
      .state(sw_state[i]),
      .rise (sw_rise[i]),
      .fall (sw_fall[i]),
      .ev_d (ev_d[i])
    );
  end

  // Uses the channels' next-cycle event terms so the flag lines up with the pulses.
  always_comb begin
    changed_d = |ev_d;
  end

  always_ff @(posedge clk) begin
    if (rst)
      changed_q <= 1'b0;
    else
      changed_q <= changed_d;
  end

  assign sw_changed = changed_q;

endmodule

// File: tb/tb_pmod_switch_debounce.sv
// Scoreboard bench for pmod_switch_debounce with STABLE_CYCLES = 4.
// Driver queues expected events; a negedge monitor checks them.
module tb_pmod_switch_debounce;

  typedef struct {
    int         cyc;
    logic [7:0] st;
    logic [7:0] rise;
    logic [7:0] fall;
  } evt_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] sw_in = 8'h00;
  logic [7:0] sw_state, sw_rise, sw_fall;
  logic       sw_changed;

  evt_t       q[$];
  int         cyc = 0;
  logic       rst_d = 1'b1;
  logic [7:0] exp_state = 8'hFF;
  int         n_chk = 0;
  int         n_fail = 0;

  pmod_switch_debounce #(
    .CHANNELS     (8),
    .STABLE_CYCLES(4),
    .IDLE_LEVEL   (1'b1)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .sw_in     (sw_in),
    .sw_state  (sw_state),
    .sw_rise   (sw_rise),
    .sw_fall   (sw_fall),
    .sw_changed(sw_changed)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    cyc   <= cyc + 1;
    rst_d <= rst;
  end

  task automatic chk(input bit ok, input string nm,
                     input logic [31:0] act, input logic [31:0] req);
    n_chk++;
    if (!ok) begin
      n_fail++;
      $display("FAIL %s cyc=%0d actual=%h required=%h", nm, cyc, act, req);
    end
  endtask

  task automatic push(input int dly, input logic [7:0] st,
                      input logic [7:0] r, input logic [7:0] f);
    evt_t e;
    e.cyc  = cyc + dly;
    e.st   = st;
    e.rise = r;
    e.fall = f;
    q.push_back(e);
  endtask

  // Monitor: pops an expectation whenever the DUT shows an event.
  always @(negedge clk) begin
    evt_t e;
    bit   pulse;
    pulse = sw_changed || (|sw_rise) || (|sw_fall);
    if (rst_d) begin
      exp_state = 8'hFF;
      chk(sw_state == 8'hFF, "rst_state", sw_state, 8'hFF);
      chk(!pulse, "rst_pulse", {sw_rise, sw_fall}, 16'h0);
    end else begin
      while (q.size() > 0 && q[0].cyc < cyc) begin
        e = q.pop_front();
        chk(1'b0, "missed_evt", cyc, e.cyc);
      end
      if (pulse) begin
        if (q.size() == 0 || q[0].cyc != cyc) begin
          chk(1'b0, "unexpected_evt", {sw_rise, sw_fall},
              (q.size() > 0) ? q[0].cyc : -1);
        end else begin
          e = q.pop_front();
          chk(sw_rise == e.rise, "evt_rise", sw_rise, e.rise);
          chk(sw_fall == e.fall, "evt_fall", sw_fall, e.fall);
          chk(sw_state == e.st, "evt_state", sw_state, e.st);
          chk(sw_changed == 1'b1, "evt_changed", sw_changed, 1'b1);
          exp_state = e.st;
        end
      end else begin
        chk(sw_state == exp_state, "hold_state", sw_state, exp_state);
      end
    end
  end

  task automatic wait_n(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    // reset held 3 edges with pins low; all fall 6 cycles after release
    rst   = 1'b1;
    sw_in = 8'h00;
    wait_n(3);
    rst = 1'b0;
    push(6, 8'h00, 8'h00, 8'hFF);
    wait_n(10);

    sw_in = 8'hFF;
    push(6, 8'hFF, 8'hFF, 8'h00);
    wait_n(10);

    // clean press on bit 0
    sw_in = 8'hFE;
    push(6, 8'hFE, 8'h00, 8'h01);
    wait_n(10);

    // bounce on bit 3, settling low
    sw_in[3] = 1'b0; wait_n(2);
    sw_in[3] = 1'b1; wait_n(2);
    sw_in[3] = 1'b0; wait_n(2);
    sw_in[3] = 1'b1; wait_n(2);
    sw_in[3] = 1'b0;
    push(6, 8'hF6, 8'h00, 8'h08);
    wait_n(10);

    // 3-cycle glitch on bit 5 must be rejected
    sw_in[5] = 1'b0; wait_n(3);
    sw_in[5] = 1'b1;
    wait_n(10);

    // simultaneous changes
    sw_in = 8'hFF;
    push(6, 8'hFF, 8'h09, 8'h00);
    wait_n(10);
    sw_in = 8'h0F;
    push(6, 8'h0F, 8'h00, 8'hF0);
    wait_n(10);
    sw_in = 8'hF0;
    push(6, 8'hF0, 8'hF0, 8'h0F);
    wait_n(10);

    sw_in = 8'hFF;
    push(6, 8'hFF, 8'h0F, 8'h00);
    wait_n(10);

    // reset while channel 1 counter is at 2
    sw_in = 8'hFD;
    wait_n(4);
    rst = 1'b1;
    wait_n(2);
    rst = 1'b0;
    push(6, 8'hFD, 8'h00, 8'h02);
    wait_n(12);

    chk(q.size() == 0, "queue_empty", q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
